// File: rtl/serv_mtimer_pkg.sv
// rtl/serv_mtimer_pkg.sv - shared constants for the machine timer
//
// Purpose: register addresses and reset values used by serv_mtimer.
// Ports:   none (package).
package serv_mtimer_pkg;

   localparam logic [1:0]  ADR_MTIME    = 2'd0;
   localparam logic [1:0]  ADR_MTIMECMP = 2'd1;
   localparam logic [1:0]  ADR_PRESCALE = 2'd2;

   // Widest supported bus is 32 bits; users slice to WIDTH.
   localparam logic [31:0] MTIME_RST    = 32'h0000_0000;
   localparam logic [31:0] MTIMECMP_RST = 32'hFFFF_FFFF;
   localparam int          PRESCALE_RST = 0;

endpackage

// File: rtl/serv_mtimer_prescaler.sv
// rtl/serv_mtimer_prescaler.sv - tick divider for the machine timer
//
// Purpose: counts 0..i_prescale and raises o_tick on the terminal count,
//          then restarts from 0. i_clr restarts the count immediately.
// Ports:
//   i_clk       clock
//   i_rst_n     asynchronous active-low reset
//   i_prescale  terminal count P (tick every P+1 cycles)
//   i_clr       restart the counter (used when P is rewritten)
//   o_tick      high in the cycle the counter equals P
module serv_mtimer_prescaler #(
   parameter int PRESCALE_W = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [PRESCALE_W-1:0] i_prescale,
   input  logic                  i_clr,
   output logic                  o_tick
);

   logic [PRESCALE_W-1:0] cnt;

   assign o_tick = (cnt == i_prescale);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         cnt <= '0;
      else if (i_clr || o_tick)
         cnt <= '0;
      else
         cnt <= cnt + PRESCALE_W'(1);
   end

endmodule

// File: rtl/serv_mtimer.sv
// rtl/serv_mtimer.sv - RISC-V style mtime/mtimecmp timer with a simple bus
//
// Purpose: free-running mtime, compare register mtimecmp and a registered
//          timer interrupt o_mtip = (mtime >= mtimecmp). Optional prescaler
//          at address 2 is compiled in with SERV_MTIMER_PRESCALE_EN.
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_wb_cyc            bus request (cyc/stb combined)
//   i_wb_we             write enable
//   i_wb_adr            0 mtime, 1 mtimecmp, 2 prescale, 3 reserved
//   i_wb_dat, i_wb_sel  write data, byte enables
//   o_wb_rdt, o_wb_ack  read data (valid with ack), one-cycle acknowledge
//   o_mtip              machine timer interrupt pending
module serv_mtimer
   import serv_mtimer_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int PRESCALE_W = 16
) (
   input  logic                                      i_clk,
   input  logic                                      i_rst_n,
   input  logic                                      i_wb_cyc,
   input  logic                                      i_wb_we,
   input  logic [1:0]                                i_wb_adr,
   input  logic [WIDTH-1:0]                          i_wb_dat,
   input  logic [((WIDTH/8 < 1) ? 1 : WIDTH/8)-1:0]  i_wb_sel,
   output logic [WIDTH-1:0]                          o_wb_rdt,
   output logic                                      o_wb_ack,
   output logic                                      o_mtip
);

   localparam int SEL_W = (WIDTH/8 < 1) ? 1 : WIDTH/8;

   logic                  start;
   logic                  wr_mtime;
   logic                  wr_mtimecmp;
   logic                  tick;
   logic [WIDTH-1:0]      wmask;
   logic [WIDTH-1:0]      mtime;
   logic [WIDTH-1:0]      mtime_inc;
   logic [WIDTH-1:0]      mtimecmp;
   logic [WIDTH-1:0]      rdt_next;
   logic [WIDTH-1:0]      prescale_rd;
   logic [PRESCALE_W-1:0] prescale_q;

   // A new transfer starts whenever the master requests and we are not in
   // the ack cycle, so a held request yields back-to-back transfers.
   assign start       = i_wb_cyc & ~o_wb_ack;
   assign wr_mtime    = start & i_wb_we & (i_wb_adr == ADR_MTIME);
   assign wr_mtimecmp = start & i_wb_we & (i_wb_adr == ADR_MTIMECMP);

   // Bit-level write mask; bits beyond the last full byte follow the top lane.
   for (genvar i = 0; i < WIDTH; i++) begin : g_mask
      localparam int LANE = (i/8 < SEL_W) ? i/8 : SEL_W-1;
      assign wmask[i] = i_wb_sel[LANE];
   end

`ifdef SERV_MTIMER_PRESCALE_EN
   logic                  wr_prescale;
   logic [PRESCALE_W-1:0] pmask;
   logic [PRESCALE_W-1:0] pdat;

   assign wr_prescale = start & i_wb_we & (i_wb_adr == ADR_PRESCALE);

   // Prescale bits above the bus width are not reachable from the bus.
   for (genvar i = 0; i < PRESCALE_W; i++) begin : g_pwr
      if (i < WIDTH) begin : g_bus
         assign pmask[i] = wmask[i];
         assign pdat[i]  = i_wb_dat[i];
      end else begin : g_none
         assign pmask[i] = 1'b0;
         assign pdat[i]  = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         prescale_q <= PRESCALE_W'(PRESCALE_RST);
      else if (wr_prescale)
         prescale_q <= (prescale_q & ~pmask) | (pdat & pmask);
   end

   serv_mtimer_prescaler #(
      .PRESCALE_W (PRESCALE_W)
   ) u_prescaler (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_prescale (prescale_q),
      .i_clr      (wr_prescale),
      .o_tick     (tick)
   );
`else
   assign prescale_q = '0;
   assign tick       = 1'b1;
`endif

   for (genvar i = 0; i < WIDTH; i++) begin : g_prd
      if (i < PRESCALE_W) begin : g_bit
         assign prescale_rd[i] = prescale_q[i];
      end else begin : g_zero
         assign prescale_rd[i] = 1'b0;
      end
   end

   // Unwritten mtime bytes still advance, so a partial write never loses a tick.
   assign mtime_inc = mtime + WIDTH'(tick);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         mtime    <= MTIME_RST[WIDTH-1:0];
         mtimecmp <= MTIMECMP_RST[WIDTH-1:0];
      end else begin
         if (wr_mtime)
            mtime <= (mtime_inc & ~wmask) | (i_wb_dat & wmask);
         else
            mtime <= mtime_inc;
         if (wr_mtimecmp)
            mtimecmp <= (mtimecmp & ~wmask) | (i_wb_dat & wmask);
      end
   end

   always_comb begin
      rdt_next = '0;
      if (start && !i_wb_we) begin
         case (i_wb_adr)
            ADR_MTIME:    rdt_next = mtime;
            ADR_MTIMECMP: rdt_next = mtimecmp;
            ADR_PRESCALE: rdt_next = prescale_rd;
            default:      rdt_next = '0;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_wb_ack <= 1'b0;
         o_wb_rdt <= '0;
         o_mtip   <= 1'b0;
      end else begin
         o_wb_ack <= start;
         o_wb_rdt <= rdt_next;
         o_mtip   <= (mtime >= mtimecmp);
      end
   end

endmodule
